// File: rtl/avr_mul_seq.sv
// avr_mul_seq: issue/hold/writeback sequencer around the AVR hardware multiplier.
module avr_mul_seq #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [4:0]  RES_ADR     = 5'd0
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic        cp2en,
  input  logic        idc_mul_start,
  input  logic        idc_fmul,
  input  logic        idc_muls,
  input  logic        idc_mulsu,
  input  logic [15:0] mr_in,
  input  logic        mc_in,
  output logic        mul_en,
  output logic        mul_fmul,
  output logic        mul_muls,
  output logic        mul_mulsu,
  output logic        mul_busy,
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_adr,
  output logic [15:0] reg_wr_data,
  output logic        sreg_cz_we,
  output logic        sreg_c,
  output logic        sreg_z
);
  typedef enum logic [1:0] {IDLE, HOLD, WB} state_t;
  localparam logic [1:0] WC = 2'(WAIT_CYCLES);
  if (WAIT_CYCLES > 3) begin : g_bad_wait
    $error("avr_mul_seq: WAIT_CYCLES must be 0..3");
  end
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] mode_q, mode_d;
  logic [2:0] mode_in;
  logic       idle, wb;
  assign mode_in = {idc_fmul, idc_muls, idc_mulsu};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (cp2en) begin
      case (state_q)
        IDLE: if (idc_mul_start) begin
          mode_d  = mode_in;
          cnt_d   = WC;
          state_d = (WC == 2'd0) ? WB : HOLD;
        end
        HOLD: begin
          cnt_d   = cnt_q - 2'd1;
          state_d = (cnt_q == 2'd1) ? WB : HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      mode_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
  // outputs are forced low while reset is asserted, even though IDLE passes inputs through
  assign idle = ireset && state_q == IDLE;
  assign wb   = ireset && state_q == WB;
  assign mul_en = idle && cp2en && idc_mul_start;
  assign {mul_fmul, mul_muls, mul_mulsu} = idle ? mode_in : (ireset ? mode_q : 3'd0);
  assign mul_busy    = idle ? idc_mul_start : (ireset && state_q == HOLD);
  assign reg_wr_en   = wb;
  assign reg_wr_adr  = RES_ADR;
  assign reg_wr_data = wb ? mr_in : 16'h0000;
  assign sreg_cz_we  = wb;
  assign sreg_c      = wb && mc_in;
  assign sreg_z      = wb && mr_in == 16'h0000;
endmodule

// File: tb/tb_avr_mul_seq.sv
// tb_avr_mul_seq: directed plus randomized checks of two sequencer instances (WAIT_CYCLES 0 and 2).
module tb_avr_mul_seq;
  logic cp2 = 1'b0, ireset = 1'b0, cp2en = 1'b1;
  logic st[2], fm[2], ms[2], su[2], mc[2];
  logic [15:0] mr[2];
  logic men[2], mfm[2], mms[2], msu[2], busy[2], wen[2], cwe[2], sc[2], sz[2];
  logic [4:0]  adr[2];
  logic [15:0] wd[2];
  int n_cmp = 0, n_err = 0;
  int wcnt[2] = '{0, 0};
  always #5 cp2 = ~cp2;
  avr_mul_seq #(.WAIT_CYCLES(0), .RES_ADR(5'd0)) u0 (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .idc_mul_start(st[0]), .idc_fmul(fm[0]),
    .idc_muls(ms[0]), .idc_mulsu(su[0]), .mr_in(mr[0]), .mc_in(mc[0]), .mul_en(men[0]),
    .mul_fmul(mfm[0]), .mul_muls(mms[0]), .mul_mulsu(msu[0]), .mul_busy(busy[0]),
    .reg_wr_en(wen[0]), .reg_wr_adr(adr[0]), .reg_wr_data(wd[0]), .sreg_cz_we(cwe[0]),
    .sreg_c(sc[0]), .sreg_z(sz[0]));
  avr_mul_seq #(.WAIT_CYCLES(2), .RES_ADR(5'd4)) u1 (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .idc_mul_start(st[1]), .idc_fmul(fm[1]),
    .idc_muls(ms[1]), .idc_mulsu(su[1]), .mr_in(mr[1]), .mc_in(mc[1]), .mul_en(men[1]),
    .mul_fmul(mfm[1]), .mul_muls(mms[1]), .mul_mulsu(msu[1]), .mul_busy(busy[1]),
    .reg_wr_en(wen[1]), .reg_wr_adr(adr[1]), .reg_wr_data(wd[1]), .sreg_cz_we(cwe[1]),
    .sreg_c(sc[1]), .sreg_z(sz[1]));
  always @(posedge cp2)
    for (int i = 0; i < 2; i++) if (cp2en && ireset && wen[i] && cwe[i]) wcnt[i]++;
  task automatic ck(string t, int d, logic [15:0] o, logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s[u%0d]: got %h expected %h", t, d, o, e);
    end
  endtask
  // Multiplier behaviour from the instruction definitions: C is bit 15 of the raw product, FMUL shifts left.
  task automatic ref_mul(int kind, logic [7:0] a, logic [7:0] b, output logic [15:0] r, output logic c);
    int x, y, p;
    logic [15:0] raw;
    x = (kind == 1 || kind == 2 || kind == 4 || kind == 5) ? int'($signed(a)) : int'(a);
    y = (kind == 1 || kind == 4) ? int'($signed(b)) : int'(b);
    p = x * y;
    raw = p[15:0];
    c = raw[15];
    r = (kind >= 3) ? {raw[14:0], 1'b0} : raw;
  endtask
  task automatic chk(int d, int k, int w, logic [2:0] md, logic [15:0] p, logic c);
    logic wb;
    wb = (k == w + 1);
    ck("mul_en", d, 16'(men[d]), 16'(k == 0 && cp2en));
    ck("busy", d, 16'(busy[d]), 16'(k <= w));
    ck("mode", d, 16'({mfm[d], mms[d], msu[d]}), 16'((k > w + 1) ? 3'd0 : md));
    ck("wr_en", d, 16'(wen[d]), 16'(wb));
    ck("cz_we", d, 16'(cwe[d]), 16'(wb));
    ck("adr", d, 16'(adr[d]), d ? 16'd4 : 16'd0);
    ck("data", d, wd[d], wb ? p : 16'h0);
    ck("c", d, 16'(sc[d]), 16'(wb && c));
    ck("z", d, 16'(sz[d]), 16'(wb && p == 16'h0));
  endtask
  task automatic rst_chk();
    for (int d = 0; d < 2; d++) begin
      ck("rst_out", d, 16'({men[d], mfm[d], mms[d], msu[d], busy[d], wen[d], cwe[d], sc[d], sz[d]}), 16'h0);
      ck("rst_data", d, wd[d], 16'h0);
      ck("rst_adr", d, 16'(adr[d]), d ? 16'd4 : 16'd0);
    end
  endtask
  // Entered and left just after a rising edge; frz picks a cycle to stall for 4 disabled clocks.
  task automatic run_op(int d, int kind, logic [7:0] a, logic [7:0] b, int frz);
    int w, wc0;
    logic [15:0] p;
    logic c;
    logic [2:0] md;
    w = d ? 2 : 0;
    wc0 = wcnt[d];
    ref_mul(kind, a, b, p, c);
    md = {kind >= 3, kind == 1 || kind == 4, kind == 2 || kind == 5};
    for (int k = 0; k <= w + 2; k++) begin
      if (k == 0) begin
        st[d] = 1'b1;
        {fm[d], ms[d], su[d]} = md;
      end else if (k <= w + 1) begin
        st[d] = 1'($urandom);
        {fm[d], ms[d], su[d]} = 3'($urandom);
      end else begin
        st[d] = 1'b0;
        {fm[d], ms[d], su[d]} = 3'd0;
      end
      mr[d] = (k == w + 1) ? p : 16'($urandom);
      mc[d] = (k == w + 1) ? c : 1'($urandom);
      if (k == frz) repeat (4) begin
        cp2en = 1'b0;
        @(negedge cp2);
        chk(d, k, w, md, p, c);
        @(posedge cp2); #1;
      end
      cp2en = 1'b1;
      @(negedge cp2);
      chk(d, k, w, md, p, c);
      @(posedge cp2); #1;
    end
    @(negedge cp2);
    ck("no_extra_wr", d, 16'(wen[d]), 16'h0);
    ck("wr_count", d, 16'(wcnt[d] - wc0), 16'd1);
    @(posedge cp2); #1;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b1; fm[d] = 1'b1; ms[d] = 1'b1; su[d] = 1'b1; mr[d] = 16'hFFFF; mc[d] = 1'b1;
    end
    #12;
    rst_chk();
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; fm[d] = 1'b0; ms[d] = 1'b0; su[d] = 1'b0; mr[d] = 16'h0; mc[d] = 1'b0;
    end
    @(posedge cp2); #1;
    ireset = 1'b1;
    @(posedge cp2); #1;
    run_op(0, 0, 8'h12, 8'h34, -1);
    run_op(0, 1, 8'hFF, 8'h02, -1);
    run_op(0, 2, 8'hFE, 8'h03, -1);
    run_op(0, 3, 8'h80, 8'h80, -1);
    run_op(0, 0, 8'h00, 8'h55, -1);
    run_op(1, 0, 8'hFF, 8'hFF, -1);
    run_op(1, 0, 8'hFF, 8'hFF, 1);
    run_op(1, 4, 8'h80, 8'h7F, 3);
    run_op(0, 5, 8'hC0, 8'h40, 1);
    run_op(0, 0, 8'h10, 8'h20, 0);
    // abort in HOLD: outputs drop asynchronously and the instruction never writes back
    st[1] = 1'b1; {fm[1], ms[1], su[1]} = 3'b000;
    @(posedge cp2); #1;
    st[1] = 1'b0;
    @(negedge cp2);
    ck("busy_hold", 1, 16'(busy[1]), 16'h1);
    #1 ireset = 1'b0;
    st[1] = 1'b1; {fm[1], ms[1], su[1]} = 3'b111;
    #1 rst_chk();
    begin
      int w0;
      w0 = wcnt[1];
      repeat (3) @(posedge cp2);
      #1;
      st[1] = 1'b0; {fm[1], ms[1], su[1]} = 3'b000;
      ireset = 1'b1;
      repeat (4) begin
        @(negedge cp2);
        ck("abort_nowr", 1, 16'(wen[1]), 16'h0);
      end
      ck("abort_cnt", 1, 16'(wcnt[1] - w0), 16'h0);
    end
    @(posedge cp2); #1;
    run_op(1, 0, 8'h03, 8'h05, -1);
    for (int i = 0; i < 24; i++)
      run_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
